leglite_pipe: RTL and testbench
===============================

# leglite_pipe

Parametrised five-stage LEGLite core (IF/ID/EX/MEM/WB), the successor to the fixed 16-bit pipelined datapath. Adds EX-stage operand forwarding, load-use interlock, taken-branch flush and a data-memory wait handshake, with configurable data width and reset PC. It sits between the instruction ROM and the data memory/IO block. The instruction format stays 16 bits wide.

## Interface
- `DW`, 16: data/register width (≥16).
- `RESET_PC`, 0: PC value after reset (even).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears PC and all pipeline registers.
- `iaddr`  out  16  program counter (IF).
- `idata`  in  16  instruction at `iaddr`, combinational.
- `draddr`  out  DW  data address (MEM).
- `dwdata`  out  DW  store data (MEM).
- `dwrite`  out  1  store strobe (MEM).
- `dread`  out  1  load strobe (MEM).
- `drdata`  in  DW  load data, valid when `dready`.
- `dready`  in  1  memory completes the current MEM access this cycle.
- `wdata_wb`  out  DW  write-back data (debug).
- `waddr_wb`  out  3  write-back register (debug).
- `regwrite_wb`  out  1  write-back enable (debug).

## Operation
- Fields: op [15:13], rm [12:10], imm7 [12:6] (signed), rn [5:3], rd [2:0]. R7 reads as 0 and ignores writes.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 ORR (rd = rn op rm); 100 ADDI (rd = rn + sext(imm7)); 101 LDUR (rd = mem[rn + sext(imm7)]); 110 STUR (mem[rn + sext(imm7)] = rd, rd read on port 2); 111 CBZ (if rd == 0, PC = PC_of_CBZ + 2·sext(imm7)).
- Arithmetic is modulo 2^DW. imm7 sign-extends to DW. The branch target is computed in 16 bits and wraps.
- Register file: 8×DW, two asynchronous reads, one synchronous write in WB. Write-first bypass: an ID read of the register being written in the same cycle returns the new value.
- Forwarding to EX operands, priority MEM over WB. Sources are ALU results in MEM and write-back data in WB. This also covers STUR store data and the CBZ rd operand. R7 is never forwarded.
- Load-use interlock: if EX holds LDUR with rd≠7 and the ID instruction reads that rd, then hold PC and IF/ID and inject one bubble into EX.
- Branch: CBZ resolves in EX. The taken decision and target are registered into MEM. In the next cycle the PC loads the target, and IF/ID, ID/EX and EX/MEM (the three younger instructions) become bubbles.
- Memory wait: while MEM holds LDUR/STUR and `dready`=0, all stages and the PC freeze. `dwrite`/`dread` stay asserted with stable address/data, and WB does not write.
- Priority when several events coincide: memory wait > branch flush > load-use stall.
- Bubbles have every control bit (regwrite, dread, dwrite, branch) at 0.

## Timing
- Reset (async assert, sync release): `iaddr`=RESET_PC. `dread`, `dwrite` and `regwrite_wb` are 0. `draddr`, `dwdata`, `wdata_wb` and `waddr_wb` are 0. The pipeline is filled with bubbles. The register file is not cleared.
- The first instruction's result is written at the end of cycle 5 after reset release.
- Throughput is 1 instruction per cycle without hazards.
- A load-use pair costs +1 cycle. A taken CBZ costs 3 cycles. A not-taken CBZ costs 0.
- Each `dready`=0 cycle adds one cycle.
- `dwrite`/`dread` may be high for several cycles for one access. Memory commits a store on the cycle where `dwrite`&&`dready` is true.
- Reset asserted mid-stall or mid-flush aborts everything. No write occurs after reset assertion.

## Structure
- `leglite_pkg`: opcode localparams, ALU-op encoding, the R7 (XZR) constant, and the pipeline-register control struct {regwrite, memtoreg, dread, dwrite, branch, alusrc, aluop}.
- Sub-module `leglite_regfile` (parametrised DW, write-first bypass, R7 hardwired zero).
- The hazard, forwarding and stall logic stays in the top level.

## Test plan
- Dependent ALU chain: ADDI r1,r7,5; ADD r2,r1,r1; SUB r3,r2,r1. Required: r1=5, r2=10, r3=5, no stall cycles (forwarding only).
- Load-use: mem[4]=0x1234; LDUR r1,[r7,#4]; ADD r2,r1,r1. Required: r2=0x2468, exactly one bubble.
- Taken CBZ r7,#+4 followed by three ADDIs. Required: none of the three write, and the next `iaddr` equals branch PC+8.
- Not-taken CBZ with r1=1. Required: fall-through instructions execute with no lost cycles.
- STUR with `dready` held 0 for 3 cycles. Required: `dwrite`, `draddr` and `dwdata` are stable for 4 cycles, the PC is frozen, and the store commits once.
- DW=32: ADDI r1,r7,-1. Required: r1=0xFFFFFFFF. Then assert reset during a stall. Required: `iaddr`=RESET_PC and `dwrite`=0 immediately.

Source files
------------

// File: rtl/leglite_pkg.sv
// rtl/leglite_pkg.sv - LEGLite opcodes, ALU encoding, XZR and pipeline control struct
package leglite_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORR  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_LDUR = 3'b101;
  localparam logic [2:0] OP_STUR = 3'b110;
  localparam logic [2:0] OP_CBZ  = 3'b111;

  // Register 7 reads as zero and discards writes.
  localparam logic [2:0] XZR = 3'd7;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_ORR = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    dread;
    logic    dwrite;
    logic    branch;
    logic    alusrc;
    alu_op_e aluop;
  } ctrl_t;

endpackage

// File: rtl/leglite_regfile.sv
// rtl/leglite_regfile.sv - 8xDW register file, two async reads, write-first bypass, R7 = 0
module leglite_regfile
  import leglite_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr1,
  input  logic [2:0]    raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  // Contents are deliberately not reset.
  logic [DW-1:0] regs_q [8];

  // Write port; XZR is never stored.
  always_ff @(posedge clock) begin
    if (we && waddr != XZR) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports: XZR is zero, a same-cycle write to the read register wins.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (raddr1 == XZR) begin
      rdata1 = '0;
    end else if (we && waddr == raddr1) begin
      rdata1 = wdata;
    end
    if (raddr2 == XZR) begin
      rdata2 = '0;
    end else if (we && waddr == raddr2) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/leglite_pipe.sv
// rtl/leglite_pipe.sv - five-stage LEGLite core with forwarding, interlock, flush and memory wait
module leglite_pipe
  import leglite_pkg::*;
#(
  parameter int          DW       = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clock,
  input  logic          reset,
  output logic [15:0]   iaddr,
  input  logic [15:0]   idata,
  output logic [DW-1:0] draddr,
  output logic [DW-1:0] dwdata,
  output logic          dwrite,
  output logic          dread,
  input  logic [DW-1:0] drdata,
  input  logic          dready,
  output logic [DW-1:0] wdata_wb,
  output logic [2:0]    waddr_wb,
  output logic          regwrite_wb
);

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
  } ifid_t;

  typedef struct packed {
    ctrl_t         ctrl;
    logic [15:0]   pc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [2:0]    rn;
    logic [2:0]    r2;
    logic [2:0]    rd;
  } idex_t;

  typedef struct packed {
    logic          regwrite;
    logic          memtoreg;
    logic          dread;
    logic          dwrite;
    logic          taken;
    logic [15:0]   target;
    logic [DW-1:0] alu;
    logic [DW-1:0] sdata;
    logic [2:0]    rd;
  } exmem_t;

  typedef struct packed {
    logic          regwrite;
    logic [DW-1:0] wdata;
    logic [2:0]    rd;
  } memwb_t;

  logic [15:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [2:0]    id_op, id_rm, id_rn, id_rd, id_r2;
  logic [6:0]    id_imm7;
  logic [DW-1:0] id_imm;
  ctrl_t         id_ctrl;
  logic          id_use_rn, id_use_r2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;

  logic [DW-1:0] ex_a, ex_b, ex_opb, ex_alu;
  logic          ex_taken;
  logic [15:0]   ex_target;

  logic mem_wait, flush, load_use, stall, wb_we;

  // Field extraction; STUR and CBZ read rd on the second port.
  assign id_op   = ifid_q.instr[15:13];
  assign id_rm   = ifid_q.instr[12:10];
  assign id_imm7 = ifid_q.instr[12:6];
  assign id_rn   = ifid_q.instr[5:3];
  assign id_rd   = ifid_q.instr[2:0];
  assign id_r2   = (id_op == OP_STUR || id_op == OP_CBZ) ? id_rd : id_rm;
  assign id_imm  = {{(DW-7){id_imm7[6]}}, id_imm7};

  // Decode into pipeline control bits; invalid slots decode as bubbles.
  always_comb begin
    id_ctrl   = '0;
    id_use_rn = 1'b0;
    id_use_r2 = 1'b0;
    if (ifid_q.valid) begin
      id_use_rn = (id_op != OP_CBZ);
      id_use_r2 = (id_op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_STUR, OP_CBZ});
      case (id_op)
        OP_ADD:  begin id_ctrl.regwrite = 1'b1; id_ctrl.aluop = ALU_ADD; end
        OP_SUB:  begin id_ctrl.regwrite = 1'b1; id_ctrl.aluop = ALU_SUB; end
        OP_AND:  begin id_ctrl.regwrite = 1'b1; id_ctrl.aluop = ALU_AND; end
        OP_ORR:  begin id_ctrl.regwrite = 1'b1; id_ctrl.aluop = ALU_ORR; end
        OP_ADDI: begin id_ctrl.regwrite = 1'b1; id_ctrl.alusrc = 1'b1; end
        OP_LDUR: begin
          id_ctrl.regwrite = 1'b1;
          id_ctrl.memtoreg = 1'b1;
          id_ctrl.dread    = 1'b1;
          id_ctrl.alusrc   = 1'b1;
        end
        OP_STUR: begin id_ctrl.dwrite = 1'b1; id_ctrl.alusrc = 1'b1; end
        default: id_ctrl.branch = 1'b1;
      endcase
      if (id_rd == XZR) begin
        id_ctrl.regwrite = 1'b0;
      end
    end
  end

  assign wb_we = memwb_q.regwrite && !mem_wait;

  leglite_regfile #(.DW(DW)) u_regfile (
    .clock  (clock),
    .we     (wb_we),
    .waddr  (memwb_q.rd),
    .wdata  (memwb_q.wdata),
    .raddr1 (id_rn),
    .raddr2 (id_r2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // EX operand forwarding (MEM ALU result before WB data) and ALU / branch resolution.
  always_comb begin
    ex_a = idex_q.a;
    ex_b = idex_q.b;
    if (idex_q.rn != XZR && exmem_q.regwrite && exmem_q.rd == idex_q.rn) begin
      ex_a = exmem_q.alu;
    end else if (idex_q.rn != XZR && memwb_q.regwrite && memwb_q.rd == idex_q.rn) begin
      ex_a = memwb_q.wdata;
    end
    if (idex_q.r2 != XZR && exmem_q.regwrite && exmem_q.rd == idex_q.r2) begin
      ex_b = exmem_q.alu;
    end else if (idex_q.r2 != XZR && memwb_q.regwrite && memwb_q.rd == idex_q.r2) begin
      ex_b = memwb_q.wdata;
    end
    ex_opb = idex_q.ctrl.alusrc ? idex_q.imm : ex_b;
    case (idex_q.ctrl.aluop)
      ALU_ADD: ex_alu = ex_a + ex_opb;
      ALU_SUB: ex_alu = ex_a - ex_opb;
      ALU_AND: ex_alu = ex_a & ex_opb;
      default: ex_alu = ex_a | ex_opb;
    endcase
    ex_taken  = idex_q.ctrl.branch && (ex_b == '0);
    ex_target = idex_q.pc + {idex_q.imm[14:0], 1'b0};
  end

  // Hazard resolution: memory wait beats branch flush beats load-use stall.
  assign mem_wait = (exmem_q.dread || exmem_q.dwrite) && !dready;
  assign flush    = exmem_q.taken && !mem_wait;
  assign load_use = idex_q.ctrl.dread && idex_q.rd != XZR &&
                    ((id_use_rn && id_rn == idex_q.rd) || (id_use_r2 && id_r2 == idex_q.rd));
  assign stall    = load_use && !mem_wait && !flush;

  // Next state of the PC and every pipeline register.
  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!mem_wait) begin
      memwb_d.regwrite = exmem_q.regwrite;
      memwb_d.wdata    = exmem_q.memtoreg ? drdata : exmem_q.alu;
      memwb_d.rd       = exmem_q.rd;
      if (flush) begin
        pc_d    = exmem_q.target;
        ifid_d  = '0;
        idex_d  = '0;
        exmem_d = '0;
      end else begin
        exmem_d.regwrite = idex_q.ctrl.regwrite;
        exmem_d.memtoreg = idex_q.ctrl.memtoreg;
        exmem_d.dread    = idex_q.ctrl.dread;
        exmem_d.dwrite   = idex_q.ctrl.dwrite;
        exmem_d.taken    = ex_taken;
        exmem_d.target   = ex_target;
        exmem_d.alu      = ex_alu;
        exmem_d.sdata    = ex_b;
        exmem_d.rd       = idex_q.rd;
        if (stall) begin
          idex_d = '0;
        end else begin
          pc_d         = pc_q + 16'd2;
          ifid_d.valid = 1'b1;
          ifid_d.pc    = pc_q;
          ifid_d.instr = idata;
          idex_d.ctrl  = id_ctrl;
          idex_d.pc    = ifid_q.pc;
          idex_d.a     = rf_rdata1;
          idex_d.b     = rf_rdata2;
          idex_d.imm   = id_imm;
          idex_d.rn    = id_rn;
          idex_d.r2    = id_r2;
          idex_d.rd    = id_rd;
        end
      end
    end
  end

  // PC and pipeline registers; reset fills the pipe with bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign iaddr       = pc_q;
  assign draddr      = exmem_q.alu;
  assign dwdata      = exmem_q.sdata;
  assign dwrite      = exmem_q.dwrite;
  assign dread       = exmem_q.dread;
  assign wdata_wb    = memwb_q.wdata;
  assign waddr_wb    = memwb_q.rd;
  assign regwrite_wb = wb_we;

endmodule

// File: tb/tb_leglite_pipe.sv
// tb/tb_leglite_pipe.sv - directed self-checking bench for leglite_pipe
module tb_leglite_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADDI = 3'd4, LDUR = 3'd5, STUR = 3'd6, CBZ = 3'd7;
  localparam logic [15:0] NOP = 16'h1C3F;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst16, rst32;
  logic        dready16 = 1'b1;
  logic        dready32;
  logic [15:0] iaddr16, idata16, draddr16, dwdata16, drdata16, wdata16;
  logic        dwrite16, dread16, rw16;
  logic [2:0]  waddr16;
  logic [15:0] iaddr32, idata32;
  logic [31:0] draddr32, dwdata32, drdata32, wdata32;
  logic        dwrite32, dread32, rw32;
  logic [2:0]  waddr32;

  logic [15:0] rom16 [128];
  logic [15:0] rom32 [128];
  logic [15:0] dmem [64];

  assign idata16  = rom16[iaddr16[7:1]];
  assign drdata16 = dmem[draddr16[5:0]];
  assign idata32  = rom32[iaddr32[7:1]];
  assign drdata32 = '0;

  leglite_pipe #(.DW(16), .RESET_PC(16'h0000)) u16 (
    .clock(clock), .reset(rst16), .iaddr(iaddr16), .idata(idata16),
    .draddr(draddr16), .dwdata(dwdata16), .dwrite(dwrite16), .dread(dread16),
    .drdata(drdata16), .dready(dready16), .wdata_wb(wdata16), .waddr_wb(waddr16),
    .regwrite_wb(rw16)
  );

  leglite_pipe #(.DW(32), .RESET_PC(16'h0040)) u32 (
    .clock(clock), .reset(rst32), .iaddr(iaddr32), .idata(idata32),
    .draddr(draddr32), .dwdata(dwdata32), .dwrite(dwrite32), .dread(dread32),
    .drdata(drdata32), .dready(dready32), .wdata_wb(wdata32), .waddr_wb(waddr32),
    .regwrite_wb(rw32)
  );

  int checks = 0;
  int failures = 0;
  int wait_req = 0;

  int          cyc, waits_done, log_n, commits, dw_cycles, stable_cycles;
  int          wc_log [16];
  logic [2:0]  wa_log [16];
  logic [15:0] wd_log [16];
  logic [15:0] iaddr_at [64];

  function automatic logic [15:0] enc_r(logic [2:0] op, logic [2:0] rm, logic [2:0] rn, logic [2:0] rd);
    return {op, rm, 4'b0000, rn, rd};
  endfunction

  function automatic logic [15:0] enc_i(logic [2:0] op, logic [6:0] imm, logic [2:0] rn, logic [2:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] pk(int c, logic [2:0] a, logic [15:0] d);
    return {c[7:0], 5'd0, a, d};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom16();
    for (int i = 0; i < 128; i++) rom16[i] = NOP;
  endtask

  task automatic run16(int ncyc);
    rst16 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst16 = 1'b0;
    repeat (ncyc) @(posedge clock);
    #2;
  endtask

  // Memory model, dready wait injection and write-back / fetch logging for the DW=16 core.
  always @(negedge clock) begin
    if (rst16) begin
      cyc = 0; waits_done = 0; log_n = 0; commits = 0; dw_cycles = 0; stable_cycles = 0;
      dready16 = 1'b1;
      for (int i = 0; i < 64; i++) begin
        dmem[i] = 16'(i * 3);
        iaddr_at[i] = '0;
      end
      dmem[4] = 16'h1234;
    end else begin
      cyc++;
      if ((dwrite16 || dread16) && waits_done < wait_req) begin
        dready16 = 1'b0;
        waits_done++;
      end else begin
        dready16 = 1'b1;
      end
      #1;
      if (cyc < 64) iaddr_at[cyc] = iaddr16;
      if (rw16 && log_n < 16) begin
        wc_log[log_n] = cyc;
        wa_log[log_n] = waddr16;
        wd_log[log_n] = wdata16;
        log_n++;
      end
      if (dwrite16) begin
        dw_cycles++;
        if (draddr16 == 16'd5 && dwdata16 == 16'd9) stable_cycles++;
      end
      if (dwrite16 && dready16) begin
        commits++;
        dmem[draddr16[5:0]] = dwdata16;
      end
    end
  end

  int          wr32_n, wr32_cyc;
  logic [2:0]  wr32_addr;
  logic [31:0] wr32_data;

  initial begin
    rst16 = 1'b1;
    rst32 = 1'b1;
    dready32 = 1'b1;

    // Dependent ALU chain, reset state first.
    clear_rom16();
    rom16[0] = enc_i(ADDI, 7'd5, 3'd7, 3'd1);
    rom16[1] = enc_r(ADD, 3'd1, 3'd1, 3'd2);
    rom16[2] = enc_r(SUB, 3'd1, 3'd2, 3'd3);
    @(posedge clock);
    #1;
    chk("rst_iaddr", 32'(iaddr16), 32'h0);
    chk("rst_strobes", {29'd0, dread16, dwrite16, rw16}, 32'h0);
    chk("rst_maddr_wdata", {draddr16, dwdata16}, 32'h0);
    chk("rst_wb", {13'd0, waddr16, wdata16}, 32'h0);
    run16(12);
    chk("alu_nwrites", 32'(log_n), 32'd3);
    chk("alu_w0", pk(wc_log[0], wa_log[0], wd_log[0]), pk(5, 3'd1, 16'd5));
    chk("alu_w1", pk(wc_log[1], wa_log[1], wd_log[1]), pk(6, 3'd2, 16'd10));
    chk("alu_w2", pk(wc_log[2], wa_log[2], wd_log[2]), pk(7, 3'd3, 16'd5));

    // Load-use: one bubble before the dependent ADD.
    clear_rom16();
    rom16[0] = enc_i(LDUR, 7'd4, 3'd7, 3'd1);
    rom16[1] = enc_r(ADD, 3'd1, 3'd1, 3'd2);
    run16(12);
    chk("lu_nwrites", 32'(log_n), 32'd2);
    chk("lu_w0", pk(wc_log[0], wa_log[0], wd_log[0]), pk(5, 3'd1, 16'h1234));
    chk("lu_w1", pk(wc_log[1], wa_log[1], wd_log[1]), pk(7, 3'd2, 16'h2468));

    // Taken CBZ r7,#+4: the three following ADDIs are squashed.
    clear_rom16();
    rom16[0] = enc_i(CBZ, 7'd4, 3'd0, 3'd7);
    for (int i = 1; i <= 4; i++) rom16[i] = enc_i(ADDI, 7'(i), 3'd7, 3'(i));
    run16(14);
    chk("br_nwrites", 32'(log_n), 32'd1);
    chk("br_w0", pk(wc_log[0], wa_log[0], wd_log[0]), pk(9, 3'd4, 16'd4));
    chk("br_iaddr_c5", 32'(iaddr_at[5]), 32'd8);
    chk("br_iaddr_c6", 32'(iaddr_at[6]), 32'd10);

    // Not-taken CBZ on r1=1 (operand forwarded from MEM).
    clear_rom16();
    rom16[0] = enc_i(ADDI, 7'd1, 3'd7, 3'd1);
    rom16[1] = enc_i(CBZ, 7'd4, 3'd0, 3'd1);
    rom16[2] = enc_i(ADDI, 7'd2, 3'd7, 3'd2);
    rom16[3] = enc_i(ADDI, 7'd3, 3'd7, 3'd3);
    run16(12);
    chk("nt_nwrites", 32'(log_n), 32'd3);
    chk("nt_w0", pk(wc_log[0], wa_log[0], wd_log[0]), pk(5, 3'd1, 16'd1));
    chk("nt_w1", pk(wc_log[1], wa_log[1], wd_log[1]), pk(7, 3'd2, 16'd2));
    chk("nt_w2", pk(wc_log[2], wa_log[2], wd_log[2]), pk(8, 3'd3, 16'd3));

    // STUR r1,[r2,#2] with three dready=0 cycles.
    clear_rom16();
    rom16[0] = enc_i(ADDI, 7'd9, 3'd7, 3'd1);
    rom16[1] = enc_i(ADDI, 7'd3, 3'd7, 3'd2);
    rom16[2] = enc_i(STUR, 7'd2, 3'd2, 3'd1);
    rom16[3] = enc_i(ADDI, 7'd7, 3'd7, 3'd3);
    wait_req = 3;
    run16(14);
    wait_req = 0;
    chk("st_dwrite_cycles", 32'(dw_cycles), 32'd4);
    chk("st_stable_cycles", 32'(stable_cycles), 32'd4);
    chk("st_commits", 32'(commits), 32'd1);
    chk("st_mem5", 32'(dmem[5]), 32'd9);
    chk("st_pc_frozen_c6", 32'(iaddr_at[6]), 32'd10);
    chk("st_pc_frozen_c9", 32'(iaddr_at[9]), 32'd10);
    chk("st_pc_resume_c10", 32'(iaddr_at[10]), 32'd12);
    chk("st_nwrites", 32'(log_n), 32'd3);
    chk("st_w0", pk(wc_log[0], wa_log[0], wd_log[0]), pk(5, 3'd1, 16'd9));
    chk("st_w1", pk(wc_log[1], wa_log[1], wd_log[1]), pk(9, 3'd2, 16'd3));
    chk("st_w2", pk(wc_log[2], wa_log[2], wd_log[2]), pk(11, 3'd3, 16'd7));
    rst16 = 1'b1;

    // DW=32: ADDI r1,r7,-1, then a store that never completes, then reset mid-stall.
    for (int i = 0; i < 128; i++) rom32[i] = NOP;
    rom32[32] = enc_i(ADDI, 7'h7F, 3'd7, 3'd1);
    rom32[36] = enc_i(STUR, 7'd3, 3'd7, 3'd1);
    dready32 = 1'b0;
    @(posedge clock);
    #1;
    chk("w32_rst_iaddr", 32'(iaddr32), 32'h40);
    rst32 = 1'b0;
    wr32_n = 0; wr32_cyc = 0; wr32_addr = '0; wr32_data = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      #1;
      if (rw32) begin
        wr32_n++;
        wr32_cyc = c;
        wr32_addr = waddr32;
        wr32_data = wdata32;
      end
    end
    chk("w32_nwrites", 32'(wr32_n), 32'd1);
    chk("w32_wcycle", 32'(wr32_cyc), 32'd5);
    chk("w32_waddr", 32'(wr32_addr), 32'd1);
    chk("w32_wdata", wr32_data, 32'hFFFF_FFFF);
    chk("w32_stall_dwrite", 32'(dwrite32), 32'd1);
    chk("w32_stall_draddr", draddr32, 32'd3);
    chk("w32_stall_dwdata", dwdata32, 32'hFFFF_FFFF);
    rst32 = 1'b1;
    #1;
    chk("w32_reset_iaddr", 32'(iaddr32), 32'h40);
    chk("w32_reset_strobes", {30'd0, dwrite32, rw32}, 32'h0);
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
